// File: rtl/vm_pkg.sv
// vm_pkg: shared widths, coin denominations and payout state encoding
package vm_pkg;
  localparam int AMT_W      = 5;
  localparam int COIN_CNT_W = 3;
  localparam logic [AMT_W-1:0] DENOM_10 = AMT_W'(10);
  localparam logic [AMT_W-1:0] DENOM_5  = AMT_W'(5);
  localparam logic [AMT_W-1:0] DENOM_2  = AMT_W'(2);
  localparam logic [AMT_W-1:0] DENOM_1  = AMT_W'(1);
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERROR
  } pay_state_t;
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: coin ejector handshake
//   coin_out   - denomination presented (0 when not valid)
//   coin_valid - coin_out valid, held until acknowledged
//   coin_ack   - ejector accepted the presented coin
interface change_dispenser_if;
  import vm_pkg::*;
  logic [AMT_W-1:0] coin_out;
  logic             coin_valid;
  logic             coin_ack;
  modport master (output coin_out, output coin_valid, input coin_ack);
  modport slave  (input coin_out, input coin_valid, output coin_ack);
endinterface

// File: rtl/change_dispenser_coin_select.sv
// coin_select: largest denomination not exceeding remaining_i (0 for 0)
//   remaining_i - amount still owed
//   denom_o     - coin to issue next
module coin_select
  import vm_pkg::*;
(
  input  logic [AMT_W-1:0] remaining_i,
  output logic [AMT_W-1:0] denom_o
);
  assign denom_o = remaining_i >= DENOM_10 ? DENOM_10 :
                   remaining_i >= DENOM_5  ? DENOM_5  :
                   remaining_i >= DENOM_2  ? DENOM_2  :
                   remaining_i >= DENOM_1  ? DENOM_1  : '0;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy change payout over a valid/ack coin ejector
//   clk, rst_n        - clock, async active-low reset
//   start_i           - begin payout (sampled in IDLE/DONE/ERROR)
//   refund_amount_i   - amount to pay out, latched on accepted start
//   coin              - ejector handshake (master side)
//   busy_o            - SELECT or WAIT_ACK
//   done_o            - one-cycle completion pulse
//   error_o           - sticky ejector timeout
//   coin_count_o      - coins issued this transaction
//   remaining_o       - amount still owed
module change_dispenser
  import vm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [AMT_W-1:0]      refund_amount_i,
  change_dispenser_if.master    coin,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [COIN_CNT_W-1:0] coin_count_o,
  output logic [AMT_W-1:0]      remaining_o
);
  pay_state_t            state_q;
  logic [AMT_W-1:0]      rem_q;
  logic [AMT_W-1:0]      coin_out_q;
  logic [COIN_CNT_W-1:0] cnt_q;
  logic [7:0]            tmo_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [AMT_W-1:0]      denom;
  coin_select u_sel (
    .remaining_i(rem_q),
    .denom_o    (denom)
  );
  // done pulses the cycle after DONE is entered, so it is simply "was in DONE"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      coin_out_q <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= state_q == ST_DONE;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i) begin
            rem_q   <= refund_amount_i;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= refund_amount_i != '0;
            state_q <= refund_amount_i != '0 ? ST_SELECT : ST_DONE;
          end else if (state_q == ST_DONE) begin
            state_q <= ST_IDLE;
          end
        end
        ST_SELECT: begin
          coin_out_q <= denom;
          valid_q    <= 1'b1;
          tmo_q      <= '0;
          state_q    <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (coin.coin_ack) begin
            coin_out_q <= '0;
            valid_q    <= 1'b0;
            rem_q      <= rem_q - coin_out_q;
            cnt_q      <= cnt_q + 1'b1;
            busy_q     <= rem_q != coin_out_q;
            state_q    <= rem_q == coin_out_q ? ST_DONE : ST_SELECT;
          end else if (tmo_q == 8'(ACK_TIMEOUT - 1)) begin
            // unacknowledged coin stays owed: rem_q is left untouched
            coin_out_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_ERROR;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign coin.coin_out   = coin_out_q;
  assign coin.coin_valid = valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = err_q;
  assign coin_count_o    = cnt_q;
  assign remaining_o     = rem_q;
endmodule
